// File: rtl/tank_pkg.sv
// Shared constants and types for the tank game: directions, wall-hit code,
// sprite sizes used by the collision checker, and the round FSM encoding.
package tank_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    localparam logic [1:0] HIT_WALL = 2'b00;

    localparam int TANK_SIZE   = 32;
    localparam int BULLET_SIZE = 4;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    // Score counters stick at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One player's single bullet: fire edge/pending, facing, launch registers,
// flight-life and cooldown counters. clear forces the slot idle.
module bullet_slot
    import tank_pkg::*;
#(
    parameter int         BULLET_LIFE  = 120,
    parameter int         COOLDOWN     = 30,
    parameter logic [2:0] RESET_FACING = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [2:0] tank_dir,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [1:0] hit,
    input  logic       launch_en,
    input  logic       clear,
    output logic       active,
    output logic [2:0] bullet_dir,
    output logic [9:0] save_x,
    output logic [9:0] save_y,
    output logic       bullet_load
);

    localparam int LIFE_W = $clog2(BULLET_LIFE + 1);
    localparam int CD_W   = $clog2(COOLDOWN + 1);

    logic              fire_q;
    logic              pending;
    logic [2:0]        facing;
    logic [LIFE_W-1:0] life;
    logic [CD_W-1:0]   cooldown;

    logic fire_edge;
    logic launch;
    logic expire;

    assign fire_edge = fire & ~fire_q;

    // An edge arriving on the tick itself still counts for that tick.
    assign launch = frame_tick & launch_en & (pending | fire_edge) & ~active
                  & (cooldown == '0);

    assign expire = (hit == HIT_WALL) || (life == LIFE_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_q      <= 1'b0;
            pending     <= 1'b0;
            facing      <= RESET_FACING;
            life        <= '0;
            cooldown    <= '0;
            active      <= 1'b0;
            bullet_dir  <= DIR_NONE;
            save_x      <= '0;
            save_y      <= '0;
            bullet_load <= 1'b0;
        end else begin
            fire_q      <= fire;
            bullet_load <= 1'b0;
            if (tank_dir != DIR_NONE) begin
                facing <= tank_dir;
            end

            if (clear) begin
                pending    <= 1'b0;
                life       <= '0;
                cooldown   <= '0;
                active     <= 1'b0;
                bullet_dir <= DIR_NONE;
            end else begin
                if (frame_tick) begin
                    pending <= 1'b0;
                end else if (fire_edge) begin
                    pending <= 1'b1;
                end

                // Launch requires an idle slot, so a dying bullet always beats a pending fire.
                if (frame_tick) begin
                    if (active) begin
                        if (expire) begin
                            active     <= 1'b0;
                            bullet_dir <= DIR_NONE;
                            life       <= '0;
                            cooldown   <= CD_W'(COOLDOWN);
                        end else begin
                            life <= life - LIFE_W'(1);
                        end
                    end else begin
                        if (cooldown != '0) begin
                            cooldown <= cooldown - CD_W'(1);
                        end
                        if (launch) begin
                            active      <= 1'b1;
                            bullet_dir  <= facing;
                            save_x      <= tank_x;
                            save_y      <= tank_y;
                            bullet_load <= 1'b1;
                            life        <= LIFE_W'(BULLET_LIFE);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tank_round_ctrl.sv
// Round/score controller for the two-player tank game: owns both bullet
// slots and the WAIT/PLAY/PAUSE/OVER FSM; all outputs are registered.
module tank_round_ctrl
    import tank_pkg::*;
#(
    parameter int BULLET_LIFE  = 120,
    parameter int COOLDOWN     = 30,
    parameter int PAUSE_FRAMES = 90,
    parameter int WIN_SCORE    = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       fire1,
    input  logic       fire2,
    input  logic [9:0] X_Tank1,
    input  logic [9:0] Y_Tank1,
    input  logic [9:0] X_Tank2,
    input  logic [9:0] Y_Tank2,
    input  logic [2:0] tank_dir1,
    input  logic [2:0] tank_dir2,
    input  logic [1:0] hit1,
    input  logic [1:0] hit2,
    input  logic       tank1_alive,
    input  logic       tank2_alive,
    output logic [2:0] bullet_dir1,
    output logic [2:0] bullet_dir2,
    output logic [9:0] saveX1,
    output logic [9:0] saveY1,
    output logic [9:0] saveX2,
    output logic [9:0] saveY2,
    output logic       bullet_load1,
    output logic       bullet_load2,
    output logic       freeze,
    output logic       respawn,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [1:0] round_state
);

    localparam int         PAUSE_W = $clog2(PAUSE_FRAMES + 1);
    localparam logic [3:0] WIN4    = 4'(WIN_SCORE);

    game_state_t        state;
    game_state_t        state_next;
    logic               start_q;
    logic [PAUSE_W-1:0] pause_cnt;

    logic               start_edge;
    logic               new_game;
    logic               active1;
    logic               active2;
    logic               p1_scores;
    logic               p2_scores;
    logic               win_reached;
    logic               slot_clear;
    logic               launch_en;

    logic               freeze_d;
    logic               respawn_d;
    logic               game_over_d;
    logic [1:0]         winner_d;
    logic [3:0]         score1_d;
    logic [3:0]         score2_d;
    logic [PAUSE_W-1:0] pause_d;

    assign start_edge  = start & ~start_q;
    assign new_game    = ((state == WAIT) || (state == OVER)) && start_edge;
    // A tank death only counts when the opponent actually has a bullet in flight.
    assign p1_scores   = ~tank2_alive & active1;
    assign p2_scores   = ~tank1_alive & active2;
    assign win_reached = (score1 == WIN4) || (score2 == WIN4);
    assign slot_clear  = (state_next != PLAY);
    assign launch_en   = (state == PLAY);
    assign round_state = state;

    bullet_slot #(
        .BULLET_LIFE  (BULLET_LIFE),
        .COOLDOWN     (COOLDOWN),
        .RESET_FACING (DIR_RIGHT)
    ) u_slot1 (
        .clk         (Clk),
        .reset       (Reset),
        .frame_tick  (frame_tick),
        .fire        (fire1),
        .tank_dir    (tank_dir1),
        .tank_x      (X_Tank1),
        .tank_y      (Y_Tank1),
        .hit         (hit1),
        .launch_en   (launch_en),
        .clear       (slot_clear),
        .active      (active1),
        .bullet_dir  (bullet_dir1),
        .save_x      (saveX1),
        .save_y      (saveY1),
        .bullet_load (bullet_load1)
    );

    bullet_slot #(
        .BULLET_LIFE  (BULLET_LIFE),
        .COOLDOWN     (COOLDOWN),
        .RESET_FACING (DIR_LEFT)
    ) u_slot2 (
        .clk         (Clk),
        .reset       (Reset),
        .frame_tick  (frame_tick),
        .fire        (fire2),
        .tank_dir    (tank_dir2),
        .tank_x      (X_Tank2),
        .tank_y      (Y_Tank2),
        .hit         (hit2),
        .launch_en   (launch_en),
        .clear       (slot_clear),
        .active      (active2),
        .bullet_dir  (bullet_dir2),
        .save_x      (saveX2),
        .save_y      (saveY2),
        .bullet_load (bullet_load2)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= WAIT;
            start_q   <= 1'b0;
            pause_cnt <= '0;
            freeze    <= 1'b0;
            respawn   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'd0;
            score1    <= 4'd0;
            score2    <= 4'd0;
        end else begin
            state     <= state_next;
            start_q   <= start;
            pause_cnt <= pause_d;
            freeze    <= freeze_d;
            respawn   <= respawn_d;
            game_over <= game_over_d;
            winner    <= winner_d;
            score1    <= score1_d;
            score2    <= score2_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT, OVER: begin
                if (start_edge) state_next = PLAY;
            end
            PLAY: begin
                if (frame_tick && (p1_scores || p2_scores)) state_next = PAUSE;
            end
            PAUSE: begin
                if (frame_tick && (pause_cnt <= PAUSE_W'(1))) begin
                    state_next = win_reached ? OVER : PLAY;
                end
            end
            default: state_next = WAIT;
        endcase
    end

    // Outputs are computed from the upcoming state so they land with it.
    always_comb begin
        freeze_d    = (state_next != PLAY);
        respawn_d   = (state_next == PLAY) && (state != PLAY);
        game_over_d = (state_next == OVER);
        winner_d    = winner;
        score1_d    = score1;
        score2_d    = score2;
        pause_d     = pause_cnt;

        if (new_game) begin
            score1_d = 4'd0;
            score2_d = 4'd0;
            winner_d = 2'd0;
        end

        if ((state == PLAY) && (state_next == PAUSE)) begin
            if (p1_scores && !p2_scores) score1_d = sat_inc4(score1);
            if (p2_scores && !p1_scores) score2_d = sat_inc4(score2);
            pause_d = PAUSE_W'(PAUSE_FRAMES);
        end else if ((state == PAUSE) && frame_tick && (pause_cnt != '0)) begin
            pause_d = pause_cnt - PAUSE_W'(1);
        end

        if (state_next == OVER) begin
            if (score1 == WIN4) begin
                winner_d = 2'd1;
            end else if (score2 == WIN4) begin
                winner_d = 2'd2;
            end else begin
                winner_d = 2'd0;
            end
        end
    end

endmodule
